dram2rgb: RTL and testbench
===========================

// Module: dram2rgb
// PURPOSE
// Frame scan-out engine: fetches a packed 32-bit/pixel frame from DRAM in bursts and
// drives a raster video stream (hsync, vsync_n, de, rgb_data).
// It is the read-side counterpart of the video-to-DRAM capture path and uses the same
// pixel word packing and {len,addr} command format.
// It sits between the DRAM read-command/read-data channel and the video output encoder.
// PARAMETERS
// H_ACTIVE   1600  active pixels per line
// H_FP       24    horizontal front porch (clocks)
// H_SYNC     80    hsync width (clocks)
// H_BP       96    horizontal back porch (clocks)
// V_ACTIVE   900   active lines per frame
// V_FP       1     vertical front porch (lines)
// V_SYNC     3     vsync width (lines)
// V_BP       96    vertical back porch (lines)
// BURST      64    max words per read command (1..255)
// FIFO_AW    8     pixel FIFO depth = 2**FIFO_AW words; must be >= BURST
// PORTS
// clk          in   1   pixel/system clock (single domain)
// rst_n        in   1   asynchronous active-low reset
// nextBASEADDR in   32  frame base byte address; sampled at frame start only
// ctrl_out     out  40  read command {len[39:32], addr[31:0]}
// ctrl_we      out  1   command valid; held until accepted
// ctrl_ready   in   1   command sink can accept
// rd_data      in   32  read data word, packed {R,B,G,8'hff}
// rd_valid     in   1   rd_data valid; no backpressure
// hsync        out  1   active-high horizontal sync
// vsync_n      out  1   active-low vertical sync
// de           out  1   data enable
// rgb_data     out  24  pixel {R,G,B}
// underflow    out  1   sticky: pixel needed while FIFO empty
// overflow     out  1   sticky: rd_valid while FIFO full
// BEHAVIOUR
// - Reset values: ctrl_out=0, ctrl_we=0, hsync=0, vsync_n=1, de=0, rgb_data=0,
//   underflow=0, overflow=0.
// - Reset places counters at h=0, v=V_ACTIVE+V_FP, so the first post-reset cycle is frame start.
// - Timing: h_cnt 0..H_TOTAL-1 wraps and advances v_cnt 0..V_TOTAL-1 (TOTAL = sum of 4 params).
//   - de_pre = h<H_ACTIVE && v<V_ACTIVE.
//   - hsync_pre when H_ACTIVE+H_FP <= h < +H_SYNC.
//   - vsync_pre when V_ACTIVE+V_FP <= v < +V_SYNC.
//   - All video outputs registered: 1 clk after the counters.
// - Frame start (h==0, v==V_ACTIVE+V_FP):
//   - base <= nextBASEADDR; req_addr <= nextBASEADDR; words_left <= H_ACTIVE*V_ACTIVE (32b).
//   - FIFO flushed; any pending command dropped.
// - Drain: if outstanding!=0 at frame start, rd_valid words are discarded (not written)
//   until outstanding reaches 0.
//   - No new command is issued while draining.
// - Request FSM:
//   - IDLE -> REQ when !drain && words_left!=0 && (2**FIFO_AW - occ - outstanding) >= BURST.
//   - REQ drives ctrl_we=1, ctrl_out={len,req_addr}, len=min(BURST,words_left);
//     ctrl_out stays stable while ctrl_ready=0.
//   - REQ -> IDLE on ctrl_we&&ctrl_ready: req_addr += len*4, words_left -= len,
//     outstanding += len.
// - outstanding decrements by 1 per rd_valid; simultaneous accept and rd_valid net correctly.
// - Credit rule guarantees occ+outstanding <= depth.
//   If rd_valid arrives with FIFO full: word dropped, overflow<=1.
// - Pop when de_pre. rgb_data <= {w[31:24], w[15:8], w[23:16]} (w = FIFO head),
//   so 0xAABBCCFF -> 0xAACCBB.
// - Pop while empty: rgb_data<=0, underflow<=1, FIFO state unchanged.
// - rgb_data=0 whenever de_pre=0.
// - Both sticky flags clear only on reset.
// - nextBASEADDR changes mid-frame take effect at the next frame start only.
// - Mid-operation reset: all state returns to reset values immediately; no partial command survives.
// TESTING
// (bench params: H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V_ACTIVE=5,V_FP=1,V_SYNC=1,V_BP=1,BURST=16,FIFO_AW=5)
// 1. Release rst_n, nextBASEADDR=0x1000, ctrl_ready=1 -> vsync_n=0 line 1 clk later;
//    first ctrl_out={8'd16,32'h1000}; second {16,0x1040}.
// 2. Frame of 40 words -> commands len 16,16,8 at 0x1000,0x1040,0x1080; no 4th command.
// 3. Memory model returns pixel i as {i,8'h00,8'hFF,8'hff} after 3 clk
//    -> de pixel k shows rgb={k,8'hFF,8'h00}, 8 per line, 5 lines; underflow=0.
// 4. ctrl_ready=0 for 10 clk while ctrl_we=1 -> ctrl_out constant, nothing counted;
//    accept on ready; no command until free >= 16.
// 5. Memory model withholds data -> first de cycle rgb_data=0, underflow=1 (sticky);
//    late words drained before the next frame's first command.
// 6. nextBASEADDR 0x1000->0x8000 mid-frame -> current frame addresses stay 0x10xx;
//    next frame's first command addr=0x8000.

Source files
------------

// File: rtl/dram2rgb.sv
// Frame scan-out engine: bursts a 32-bit/pixel frame out of DRAM into a pixel FIFO
// and plays it back as a registered raster stream (hsync, vsync_n, de, rgb_data).
//
// state  | meaning
// IDLE   | no command pending; waits for credit, remaining words and no drain
// REQ    | command {len,addr} presented on ctrl_out, held until ctrl_ready
module dram2rgb #(
    parameter int H_ACTIVE = 1600,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 80,
    parameter int H_BP     = 96,
    parameter int V_ACTIVE = 900,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 96,
    parameter int BURST    = 64,
    parameter int FIFO_AW  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] nextBASEADDR,
    output logic [39:0] ctrl_out,
    output logic        ctrl_we,
    input  logic        ctrl_ready,
    input  logic [31:0] rd_data,
    input  logic        rd_valid,
    output logic        hsync,
    output logic        vsync_n,
    output logic        de,
    output logic [23:0] rgb_data,
    output logic        underflow,
    output logic        overflow
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int OW      = FIFO_AW + 2;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_DE_END = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_DE_END = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0]   FRAME_WORDS = 32'(H_ACTIVE * V_ACTIVE);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t             state, state_nxt;
    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic [31:0]        req_addr;
    logic [31:0]        words_left;
    logic [OW-1:0]      outstanding, outstanding_nxt;
    logic               drain;
    logic [23:0]        mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr, rd_ptr, occ;
    logic               frame_start, de_pre, hsync_pre, vsync_pre;
    logic               full, empty, accept, push, dec, go;
    logic [7:0]         len;
    logic [31:0]        committed;
    logic               unused_bits;

    assign unused_bits = &{1'b0, rd_data[7:0]};

    assign frame_start = (h_cnt == '0) && (v_cnt == V_VS_BEG);
    assign de_pre      = (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
    assign hsync_pre   = (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
    assign vsync_pre   = (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);

    assign occ       = wr_ptr - rd_ptr;
    assign full      = (occ == (FIFO_AW + 1)'(DEPTH));
    assign empty     = (occ == '0);
    assign accept    = ctrl_we && ctrl_ready;
    assign push      = rd_valid && !drain && !frame_start && !full;
    assign dec       = rd_valid && (outstanding != '0);
    assign len       = (words_left < 32'(BURST)) ? words_left[7:0] : 8'(BURST);
    assign committed = 32'(occ) + 32'(outstanding);
    // Credit counts words already in flight so the FIFO can never be overrun.
    assign go        = !drain && !frame_start && (words_left != '0)
                       && (committed + 32'(BURST) <= 32'(DEPTH));

    assign outstanding_nxt = outstanding + (accept ? OW'(len) : '0) - (dec ? OW'(1) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= V_VS_BEG;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = S_REQ;
            S_REQ:   if (ctrl_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (frame_start) state_nxt = S_IDLE;
    end

    always_comb begin
        ctrl_we  = 1'b0;
        ctrl_out = '0;
        if (state == S_REQ) begin
            ctrl_we  = 1'b1;
            ctrl_out = {len, req_addr};
        end
    end

    // A command accepted on the frame-start cycle still counts as in flight; drain absorbs it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr    <= '0;
            words_left  <= '0;
            outstanding <= '0;
            drain       <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (frame_start) begin
                req_addr   <= nextBASEADDR;
                words_left <= FRAME_WORDS;
                drain      <= (outstanding_nxt != '0);
            end else begin
                if (accept) begin
                    req_addr   <= req_addr + {22'd0, len, 2'b00};
                    words_left <= words_left - 32'(len);
                end
                if (outstanding_nxt == '0) drain <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {rd_data[31:24], rd_data[15:8], rd_data[23:16]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hsync     <= 1'b0;
            vsync_n   <= 1'b1;
            de        <= 1'b0;
            rgb_data  <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            hsync   <= hsync_pre;
            vsync_n <= !vsync_pre;
            de      <= de_pre;
            if (rd_valid && !drain && !frame_start && full) overflow <= 1'b1;
            if (frame_start) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (de_pre && !empty) rd_ptr <= rd_ptr + 1'b1;
            end
            if (de_pre && !empty) begin
                rgb_data <= mem[rd_ptr[FIFO_AW-1:0]];
            end else begin
                rgb_data <= '0;
                if (de_pre) underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dram2rgb.sv
// Directed bench for dram2rgb on a tiny 8x5 raster with a latency-3 memory model
// that can withhold read data to force underflow and a stale-word drain.
module tb_dram2rgb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] nextBASEADDR;
    logic [39:0] ctrl_out;
    logic        ctrl_we;
    logic        ctrl_ready;
    logic [31:0] rd_data = '0;
    logic        rd_valid = 1'b0;
    logic        hsync, vsync_n, de, underflow, overflow;
    logic [23:0] rgb_data;

    dram2rgb #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BURST(16), .FIFO_AW(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .nextBASEADDR(nextBASEADDR),
        .ctrl_out(ctrl_out), .ctrl_we(ctrl_we), .ctrl_ready(ctrl_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .hsync(hsync), .vsync_n(vsync_n), .de(de), .rgb_data(rgb_data),
        .underflow(underflow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } word_t;

    word_t       wq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          delivered = 0;
    int          cmd_count = 0;
    logic [31:0] cmd_addr [16];
    logic [7:0]  cmd_len  [16];
    int          cmd_deliv[16];
    logic        withhold = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    int          base_cyc = 0;

    // Accepted commands are logged and expanded into words due 3 clocks later, one per clock.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && ctrl_we && ctrl_ready) begin
            if (cmd_count < 16) begin
                cmd_addr[cmd_count]  = ctrl_out[31:0];
                cmd_len[cmd_count]   = ctrl_out[39:32];
                cmd_deliv[cmd_count] = delivered;
            end
            for (int j = 0; j < int'(ctrl_out[39:32]); j++) begin
                word_t w;
                logic [7:0] idx;
                idx = 8'(int'(ctrl_out[11:2]) + j);
                w.data = {idx, 8'h00, 8'hFF, 8'hFF};
                w.due  = (cyc + 3 > last_due + 1) ? cyc + 3 : last_due + 1;
                last_due = w.due;
                wq.push_back(w);
            end
            cmd_count = cmd_count + 1;
        end
    end

    always @(negedge clk) begin
        if (!withhold && wq.size() > 0 && wq[0].due <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = wq[0].data;
            void'(wq.pop_front());
            delivered = delivered + 1;
        end else begin
            rd_valid = 1'b0;
            rd_data  = '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int n);
        while (cyc - base_cyc < n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int n_de, n_hs, n_vs, first_de, k, n;
        logic [39:0] held;
        logic        stable;

        rst_n = 1'b0;
        nextBASEADDR = 32'h1000;
        ctrl_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ctrl_out", 64'(ctrl_out), 64'd0);
        check("rst_ctrl_we", 64'(ctrl_we), 64'd0);
        check("rst_hsync", 64'(hsync), 64'd0);
        check("rst_vsync_n", 64'(vsync_n), 64'd1);
        check("rst_de", 64'(de), 64'd0);
        check("rst_rgb", 64'(rgb_data), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        rst_n = 1'b1;
        base_cyc = cyc;

        n_de = 0; n_hs = 0; n_vs = 0; first_de = -1; k = 0;
        for (int i = 1; i <= 112; i++) begin
            go_to(i);
            if (i == 1) check("vsync_first_clk", 64'(vsync_n), 64'd0);
            if (i == 2) begin
                check("first_cmd_we", 64'(ctrl_we), 64'd1);
                check("first_cmd_out", 64'(ctrl_out), {24'd0, 8'd16, 32'h1000});
            end
            if (hsync) n_hs++;
            if (!vsync_n) n_vs++;
            if (de) begin
                if (first_de < 0) first_de = i;
                check($sformatf("f0_pix%0d", k), 64'(rgb_data), 64'({k[7:0], 8'hFF, 8'h00}));
                k++;
                n_de++;
            end
        end
        check("f0_de_count", 64'(n_de), 64'd40);
        check("f0_hsync_clks", 64'(n_hs), 64'd16);
        check("f0_vsync_clks", 64'(n_vs), 64'd14);
        check("f0_first_de_clk", 64'(first_de), 64'd29);
        check("f0_cmd_count", 64'(cmd_count), 64'd3);
        check("f0_cmd0", 64'({cmd_len[0], cmd_addr[0]}), {24'd0, 8'd16, 32'h1000});
        check("f0_cmd1", 64'({cmd_len[1], cmd_addr[1]}), {24'd0, 8'd16, 32'h1040});
        check("f0_cmd2", 64'({cmd_len[2], cmd_addr[2]}), {24'd0, 8'd8, 32'h1080});
        check("f0_underflow", 64'(underflow), 64'd0);

        ctrl_ready = 1'b0;
        go_to(114);
        check("stall_we", 64'(ctrl_we), 64'd1);
        check("stall_out", 64'(ctrl_out), {24'd0, 8'd16, 32'h1000});
        held = ctrl_out;
        stable = 1'b1;
        for (int i = 115; i <= 124; i++) begin
            go_to(i);
            if (ctrl_out !== held || ctrl_we !== 1'b1) stable = 1'b0;
        end
        check("stall_stable", 64'(stable), 64'd1);
        check("stall_no_count", 64'(cmd_count), 64'd3);
        ctrl_ready = 1'b1;
        go_to(125);
        check("stall_accept", 64'(cmd_count), 64'd4);

        go_to(141);
        check("f1_first_de", 64'(de), 64'd1);
        check("f1_pix0", 64'(rgb_data), 64'h00FF00);
        check("f1_credit_wait", 64'(cmd_count), 64'd5);

        go_to(150);
        nextBASEADDR = 32'h8000;
        go_to(224);
        check("f1_cmd_count", 64'(cmd_count), 64'd6);
        check("f1_cmd3", 64'({cmd_len[3], cmd_addr[3]}), {24'd0, 8'd16, 32'h1000});
        check("f1_cmd4", 64'({cmd_len[4], cmd_addr[4]}), {24'd0, 8'd16, 32'h1040});
        check("f1_cmd5", 64'({cmd_len[5], cmd_addr[5]}), {24'd0, 8'd8, 32'h1080});
        check("f1_underflow", 64'(underflow), 64'd0);

        withhold = 1'b1;
        go_to(253);
        check("f2_first_de", 64'(de), 64'd1);
        check("f2_empty_rgb", 64'(rgb_data), 64'd0);
        check("f2_underflow", 64'(underflow), 64'd1);
        go_to(336);
        check("f2_underflow_sticky", 64'(underflow), 64'd1);
        check("f2_cmd_count", 64'(cmd_count), 64'd8);
        check("f2_cmd6", 64'({cmd_len[6], cmd_addr[6]}), {24'd0, 8'd16, 32'h8000});
        check("f2_cmd7", 64'({cmd_len[7], cmd_addr[7]}), {24'd0, 8'd16, 32'h8040});

        go_to(340);
        withhold = 1'b0;
        go_to(365);
        check("f3_first_de", 64'(de), 64'd1);
        check("f3_stale_dropped", 64'(rgb_data), 64'd0);
        n = 366;
        while (cmd_count < 9 && n < 600) begin
            go_to(n);
            n++;
        end
        check("f3_cmd_issued", 64'(cmd_count >= 9), 64'd1);
        check("f3_cmd8", 64'({cmd_len[8], cmd_addr[8]}), {24'd0, 8'd16, 32'h8000});
        check("f3_after_drain", 64'(cmd_deliv[8]), 64'd112);
        check("overflow_clear", 64'(overflow), 64'd0);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_we", 64'(ctrl_we), 64'd0);
        check("midrst_out", 64'(ctrl_out), 64'd0);
        check("midrst_vsync_n", 64'(vsync_n), 64'd1);
        check("midrst_de", 64'(de), 64'd0);
        check("midrst_underflow", 64'(underflow), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
